// File: rtl/rv32i_alu_issue.sv
// rv32i_alu_issue: RV32I decode/issue stage feeding a purely combinational ALU.
// Decodes the instruction, builds the immediate and muxes the A/B operands. The
// result is registered behind a valid/ready handshake, with a one-entry skid
// register so that fetch sees a registered in_ready.
// Optional feature: define RV32I_ISSUE_FWD_EN to add a write-back forwarding port
// (wb_valid, wb_rd, wb_data) that overrides stale register-file data at accept.

package rv32i_alu_issue_pkg;

    typedef logic [31:0] RV32I_OPERAND_t;

    // ADDI must stay at encoding 0: the reset and illegal value of the entry is all-zero.
    typedef enum logic [5:0] {
        ADDI = 6'd0, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LUI, AUIPC, JAL, JALR, FENCE, ECALL, EBREAK
    } RV32I_INSTRUCTION_MNEMONIC_t;

endpackage

module rv32i_alu_issue
    import rv32i_alu_issue_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int LINK_OFFSET = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 inst,
    input  logic [XLEN-1:0]             pc,
    input  logic [XLEN-1:0]             rs1_data,
    input  logic [XLEN-1:0]             rs2_data,
`ifdef RV32I_ISSUE_FWD_EN
    input  logic                        wb_valid,
    input  logic [4:0]                  wb_rd,
    input  logic [XLEN-1:0]             wb_data,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             a,
    output logic [XLEN-1:0]             b,
    output logic [XLEN-1:0]             rs1,
    output logic [XLEN-1:0]             rs2,
    output logic [XLEN-1:0]             imm,
    output RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
    output logic [4:0]                  rd_idx,
    output logic                        illegal
);

    typedef struct packed {
        logic [XLEN-1:0]             a;
        logic [XLEN-1:0]             b;
        logic [XLEN-1:0]             rs1;
        logic [XLEN-1:0]             rs2;
        logic [XLEN-1:0]             imm;
        RV32I_INSTRUCTION_MNEMONIC_t mn;
        logic [4:0]                  rd;
        logic                        ill;
    } entry_t;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] r1_val, r2_val;
    logic [XLEN-1:0] shamt;
    logic            bad;
    entry_t          dec;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;

    assign opc     = inst[6:0];
    assign f3      = inst[14:12];
    assign f7      = inst[31:25];
    assign rs1_idx = inst[19:15];
    assign rs2_idx = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign shamt = {{(XLEN-5){1'b0}}, inst[24:20]};

    // Register operand values: optional write-back override, then x0 reads as zero.
    always_comb begin
        r1_val = rs1_data;
        r2_val = rs2_data;
`ifdef RV32I_ISSUE_FWD_EN
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_idx)) r1_val = wb_data;
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_idx)) r2_val = wb_data;
`endif
        if (rs1_idx == 5'd0) r1_val = '0;
        if (rs2_idx == 5'd0) r2_val = '0;
    end

    // Instruction decode and A/B operand selection.
    always_comb begin
        bad     = 1'b0;
        dec     = '0;
        dec.mn  = ADDI;
        dec.rs1 = r1_val;
        dec.rs2 = r2_val;
        dec.rd  = inst[11:7];
        case (opc)
            7'b0110111: begin
                dec.mn  = LUI;
                dec.a   = {12'b0, inst[31:12]};
                dec.imm = imm_u;
            end
            7'b0010111: begin
                dec.mn  = AUIPC;
                dec.a   = {12'b0, inst[31:12]};
                dec.b   = pc;
                dec.imm = imm_u;
            end
            7'b1101111: begin
                dec.mn  = JAL;
                dec.a   = pc;
                dec.b   = XLEN'(LINK_OFFSET);
                dec.imm = imm_j;
            end
            7'b1100111: begin
                dec.mn  = JALR;
                dec.a   = pc;
                dec.b   = XLEN'(LINK_OFFSET);
                dec.imm = imm_i;
                bad     = (f3 != 3'b000);
            end
            7'b1100011: begin
                dec.a   = r1_val;
                dec.b   = r2_val;
                dec.imm = imm_b;
                case (f3)
                    3'b000:  dec.mn = BEQ;
                    3'b001:  dec.mn = BNE;
                    3'b100:  dec.mn = BLT;
                    3'b101:  dec.mn = BGE;
                    3'b110:  dec.mn = BLTU;
                    3'b111:  dec.mn = BGEU;
                    default: bad = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec.a   = r1_val;
                dec.b   = imm_i;
                dec.imm = imm_i;
                case (f3)
                    3'b000:  dec.mn = LB;
                    3'b001:  dec.mn = LH;
                    3'b010:  dec.mn = LW;
                    3'b100:  dec.mn = LBU;
                    3'b101:  dec.mn = LHU;
                    default: bad = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec.a   = r1_val;
                dec.b   = imm_s;
                dec.imm = imm_s;
                case (f3)
                    3'b000:  dec.mn = SB;
                    3'b001:  dec.mn = SH;
                    3'b010:  dec.mn = SW;
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.a   = r1_val;
                dec.b   = imm_i;
                dec.imm = imm_i;
                case (f3)
                    3'b000: dec.mn = ADDI;
                    3'b010: dec.mn = SLTI;
                    3'b011: dec.mn = SLTIU;
                    3'b100: dec.mn = XORI;
                    3'b110: dec.mn = ORI;
                    3'b111: dec.mn = ANDI;
                    3'b001: begin
                        dec.b  = shamt;
                        dec.mn = SLLI;
                        bad    = (f7 != 7'b0000000);
                    end
                    default: begin
                        dec.b = shamt;
                        if (f7 == 7'b0000000)      dec.mn = SRLI;
                        else if (f7 == 7'b0100000) dec.mn = SRAI;
                        else                       bad = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                dec.a = r1_val;
                dec.b = r2_val;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec.mn = ADD;
                        3'b001:  dec.mn = SLL;
                        3'b010:  dec.mn = SLT;
                        3'b011:  dec.mn = SLTU;
                        3'b100:  dec.mn = XOR;
                        3'b101:  dec.mn = SRL;
                        3'b110:  dec.mn = OR;
                        default: dec.mn = AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec.mn = SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec.mn = SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            7'b0001111: begin
                dec.mn = FENCE;
                bad    = (f3 != 3'b000);
            end
            7'b1110011: begin
                if (inst[31:7] == 25'd0)                      dec.mn = ECALL;
                else if (inst[31:7] == {12'h001, 13'b0})      dec.mn = EBREAK;
                else                                          bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec.mn  = ADDI;
            dec.a   = '0;
            dec.b   = '0;
            dec.imm = '0;
            dec.rd  = 5'd0;
        end
        dec.ill = bad;
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;

    // Output/skid handshake: skid drains first, flush discards everything including a same-cycle accept.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // State registers; all-zero entry decodes as a clean ADDI with zero operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = out_q.a;
    assign b         = out_q.b;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign imm       = out_q.imm;
    assign mnemonic  = out_q.mn;
    assign rd_idx    = out_q.rd;
    assign illegal   = out_q.ill;

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// tb_rv32i_alu_issue: directed vector table plus handshake corner-case sequences.
// Build with RV32I_ISSUE_FWD_EN defined to also exercise the forwarding port.

module tb_rv32i_alu_issue;
    import rv32i_alu_issue_pkg::*;

    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a, b, rs1, rs2, imm;
    RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
    logic [4:0]  rd_idx;
    logic        illegal;
`ifdef RV32I_ISSUE_FWD_EN
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_alu_issue dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
`ifdef RV32I_ISSUE_FWD_EN
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a        (a),
        .b        (b),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .mnemonic (mnemonic),
        .rd_idx   (rd_idx),
        .illegal  (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string                       name;
        logic [31:0]                 inst;
        logic [31:0]                 pc;
        logic [31:0]                 r1d;
        logic [31:0]                 r2d;
        RV32I_INSTRUCTION_MNEMONIC_t mn;
        logic [31:0]                 a;
        logic [31:0]                 b;
        logic [31:0]                 rs1;
        logic [31:0]                 rs2;
        logic [31:0]                 imm;
        logic [4:0]                  rd;
        logic                        ill;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(string nm, logic [31:0] i, logic [31:0] p, logic [31:0] d1,
                                logic [31:0] d2, RV32I_INSTRUCTION_MNEMONIC_t m, logic [31:0] ea,
                                logic [31:0] eb, logic [31:0] e1, logic [31:0] e2,
                                logic [31:0] ei, logic [4:0] er, logic el);
        vec_t v;
        v.name = nm; v.inst = i; v.pc = p; v.r1d = d1; v.r2d = d2; v.mn = m;
        v.a = ea; v.b = eb; v.rs1 = e1; v.rs2 = e2; v.imm = ei; v.rd = er; v.ill = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] d1, input logic [31:0] d2);
        inst = i; pc = p; rs1_data = d1; rs2_data = d2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_entry(input vec_t v);
        chk({v.name, ".valid"},   32'(out_valid),       32'd1);
        chk({v.name, ".mn"},      32'(mnemonic),        32'(v.mn));
        chk({v.name, ".a"},       a,                    v.a);
        chk({v.name, ".b"},       b,                    v.b);
        chk({v.name, ".rs1"},     rs1,                  v.rs1);
        chk({v.name, ".rs2"},     rs2,                  v.rs2);
        chk({v.name, ".imm"},     imm,                  v.imm);
        chk({v.name, ".rd"},      32'(rd_idx),          32'(v.rd));
        chk({v.name, ".illegal"}, 32'(illegal),         32'(v.ill));
    endtask

    initial begin
        vq.push_back(mk("addi",     32'h0051_0093, 32'h1000, 32'd10,  D2, ADDI,  32'd10,  32'd5,   32'd10, D2,  32'd5,         5'd1,  1'b0));
        vq.push_back(mk("lui",      32'h1234_52B7, 32'h1000, D1,      D2, LUI,   32'h12345, 32'd0, D1,     D2,  32'h1234_5000, 5'd5,  1'b0));
        vq.push_back(mk("auipc",    32'h0000_1397, 32'h0100, D1,      D2, AUIPC, 32'h1,   32'h100, 32'd0,  32'd0, 32'h1000,    5'd7,  1'b0));
        vq.push_back(mk("beq_m4",   32'hFE00_0EE3, 32'h1000, 32'd0,   32'd0, BEQ, 32'd0,  32'd0,   32'd0,  32'd0, 32'hFFFF_FFFC, 5'd29, 1'b0));
        vq.push_back(mk("bne_p8",   32'h0020_9463, 32'h1000, D1,      D2, BNE,   D1,      D2,      D1,     D2,  32'd8,         5'd8,  1'b0));
        vq.push_back(mk("add",      32'h0021_01B3, 32'h1000, D1,      D2, ADD,   D1,      D2,      D1,     D2,  32'd0,         5'd3,  1'b0));
        vq.push_back(mk("sub",      32'h4021_01B3, 32'h1000, D1,      D2, SUB,   D1,      D2,      D1,     D2,  32'd0,         5'd3,  1'b0));
        vq.push_back(mk("add_x0",   32'h0020_01B3, 32'h1000, 32'hDEAD, D2, ADD,  32'd0,   D2,      32'd0,  D2,  32'd0,         5'd3,  1'b0));
        vq.push_back(mk("srai",     32'h4032_D213, 32'h1000, D1,      D2, SRAI,  D1,      32'd3,   D1,     D2,  32'h403,       5'd4,  1'b0));
        vq.push_back(mk("slli_bad", 32'h4032_9213, 32'h1000, D1,      D2, ADDI,  32'd0,   32'd0,   D1,     D2,  32'd0,         5'd0,  1'b1));
        vq.push_back(mk("all_ones", 32'hFFFF_FFFF, 32'h1000, D1,      D2, ADDI,  32'd0,   32'd0,   D1,     D2,  32'd0,         5'd0,  1'b1));
        vq.push_back(mk("lw_m8",    32'hFF80_A303, 32'h1000, D1,      D2, LW,    D1,      32'hFFFF_FFF8, D1, D2, 32'hFFFF_FFF8, 5'd6, 1'b0));
        vq.push_back(mk("sw_p12",   32'h0020_A623, 32'h1000, D1,      D2, SW,    D1,      32'd12,  D1,     D2,  32'd12,        5'd12, 1'b0));
        vq.push_back(mk("jal",      32'h0100_00EF, 32'h2000, D1,      D2, JAL,   32'h2000, 32'd4,  32'd0,  D2,  32'd16,        5'd1,  1'b0));
        vq.push_back(mk("jalr",     32'h0000_8067, 32'h3000, D1,      D2, JALR,  32'h3000, 32'd4,  D1,     32'd0, 32'd0,       5'd0,  1'b0));

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
`ifdef RV32I_ISSUE_FWD_EN
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
`endif
        tick(); tick();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.a",         a,              32'd0);
        chk("rst.imm",       imm,            32'd0);
        chk("rst.mn",        32'(mnemonic),  32'(ADDI));
        chk("rst.illegal",   32'(illegal),   32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);

        // Decode table: one accept per vector, output always ready.
        foreach (vq[i]) begin
            drive(vq[i].inst, vq[i].pc, vq[i].r1d, vq[i].r2d);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk_entry(vq[i]);
        end
        tick();
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Stall: three back-to-back inputs, only two taken, then drained in order.
        out_ready = 1'b0;
        drive(32'h0051_0093, 32'h0, 32'd10, D2); in_valid = 1'b1;
        tick();
        chk("skid.a_rd",      32'(rd_idx),    32'd1);
        chk("skid.in_ready1", 32'(in_ready),  32'd1);
        drive(32'h0051_0113, 32'h0, 32'd20, D2);
        tick();
        chk("skid.in_ready2", 32'(in_ready),  32'd0);
        chk("skid.hold_rd",   32'(rd_idx),    32'd1);
        drive(32'h0051_0193, 32'h0, 32'd30, D2);
        tick();
        chk("skid.in_ready3", 32'(in_ready),  32'd0);
        chk("skid.hold_val",  32'(out_valid), 32'd1);
        chk("skid.hold_a",    a,              32'd10);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("skid.second_rd", 32'(rd_idx),    32'd2);
        chk("skid.second_a",  a,              32'd20);
        chk("skid.second_v",  32'(out_valid), 32'd1);
        chk("skid.ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("skid.no_third",  32'(out_valid), 32'd0);

        // Flush with skid full: everything dropped, including the same-cycle input.
        out_ready = 1'b0;
        drive(32'h0051_0093, 32'h0, 32'd10, D2); in_valid = 1'b1;
        tick();
        drive(32'h0051_0113, 32'h0, 32'd20, D2);
        tick();
        chk("flush.pre_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(32'h0051_0193, 32'h0, 32'd30, D2);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        tick();
        chk("flush.stay_empty", 32'(out_valid), 32'd0);

        // Flush beats an accept into an empty stage.
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_acc.out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("flush_acc.no_late", 32'(out_valid), 32'd0);

        // Reset mid-transfer with an illegal entry on the output and skid full.
        out_ready = 1'b0;
        drive(32'hFFFF_FFFF, 32'h0, D1, D2); in_valid = 1'b1;
        tick();
        chk("rstmid.pre_ill", 32'(illegal), 32'd1);
        drive(32'h0051_0113, 32'h0, 32'd20, D2);
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.out_valid", 32'(out_valid), 32'd0);
        chk("rstmid.in_ready",  32'(in_ready),  32'd1);
        chk("rstmid.illegal",   32'(illegal),   32'd0);
        chk("rstmid.rs1",       rs1,            32'd0);
        out_ready = 1'b1;
        tick();
        chk("rstmid.no_skid", 32'(out_valid), 32'd0);

`ifdef RV32I_ISSUE_FWD_EN
        // Write-back forwarding on both sources; x0 target never forwards.
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
        drive(32'h0021_01B3, 32'h0, D1, D2); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fwd.a",   a,   32'd7);
        chk("fwd.b",   b,   32'd7);
        chk("fwd.rs1", rs1, 32'd7);
        chk("fwd.rs2", rs2, 32'd7);
        wb_rd = 5'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fwd0.a", a, D1);
        chk("fwd0.b", b, D2);
        wb_valid = 1'b0; wb_rd = 5'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fwd_off.rs1", rs1, D1);
        wb_valid = 1'b0; wb_rd = 5'd0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
